serial_adder16: RTL and testbench
=================================

// Module: serial_adder16
// PURPOSE
//   Bit-serial two-operand adder for the 16-bit datapath. Contains one full-adder cell,
//   a carry flip-flop and operand/result shift registers.
//   Adds two WIDTH-bit operands LSB-first in WIDTH cycles under a start/busy/done handshake.
//   It replaces a wide ripple adder where area matters. Its output feeds the ALU result mux.
// PARAMETERS
//   WIDTH   16   operand/result width in bits; legal range 2..32
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   reset   in   1      asynchronous, active-high; clears all state immediately
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  operand A; captured on the accepting start edge
//   b       in   WIDTH  operand B; captured on the accepting start edge
//   cin     in   1      carry-in; captured on the accepting start edge
//   sum     out  WIDTH  result; registered; held until the next accepted start
//   cout    out  1      final carry-out; registered; held with sum
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse marking sum/cout valid
// BEHAVIOUR
//   Reset: state=IDLE; sum=0, cout=0, busy=0, done=0; operand regs, carry FF, bit counter=0.
//   States:
//   - IDLE -> RUN when start=1.
//   - RUN -> DONE after WIDTH bit-cycles.
//   - DONE -> IDLE unconditionally, after 1 cycle.
//   Accept edge (IDLE, start=1):
//   - sra<=a, srb<=b, carry<=cin, cnt<=0, busy<=1.
//   RUN, each edge:
//   - s = sra[0]^srb[0]^carry.
//   - carry <= maj(sra[0],srb[0],carry).
//   - sra/srb shift right by 1.
//   - result reg shifts right, taking s into the MSB.
//   - cnt++.
//   Last bit:
//   - On the edge where cnt==WIDTH-1, the last bit is processed and state<=DONE.
//   - On the same edge: sum<=final result, cout<=final carry, busy<=0, done<=1.
//   Latency:
//   - start accepted at edge E; done=1 in the cycle after edge E+WIDTH.
//   - done=0 again after edge E+WIDTH+1.
//   - Next start can be accepted at edge E+WIDTH+2 at the earliest.
//   Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no saturation.
//   Boundary conditions:
//   - start while busy or in DONE: ignored, no effect on the operation in flight.
//   - a/b/cin changes after the accept edge: ignored (operands are captured).
//   - start held high continuously: a new operation is accepted each time IDLE is reached.
//   - reset mid-RUN: aborts immediately; outputs return to their reset values; no done pulse.
//   - sum/cout are never partially updated while busy; they hold the previous result.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined:
//   - Adds input port sub (1 bit, captured on the accept edge).
//   - sub=1: operand B is inverted at capture and carry is forced to 1, ignoring cin.
//     Result is a - b; cout=1 means no borrow.
//   - sub=0: identical to plain add.
//   SERIAL_ADDER_SUB_EN undefined:
//   - No sub port; add only.
//   - Timing and handshake are identical in both builds.
// TESTING
//   1. reset high 2 cycles, release -> sum=0000, cout=0, busy=0, done=0.
//   2. a=0001,b=0001,cin=0,start -> busy for 16 cycles; done pulse 1 cycle; sum=0002, cout=0.
//   3. a=FFFF,b=0001,cin=0 -> sum=0000, cout=1.
//      a=0000,b=0000,cin=1 -> sum=0001, cout=0.
//   4. a=1234,b=4321 accepted; at RUN cycle 5 pulse start with a=FFFF,b=FFFF
//      -> sum=5555, cout=0; exactly one done pulse.
//   5. a=AAAA,b=5555 accepted; reset at RUN cycle 8 -> busy=0, sum=0000 immediately, no done;
//      then a=8000,b=8000 -> sum=0000, cout=1.
//   6. SERIAL_ADDER_SUB_EN: sub=1,a=0005,b=0003 -> sum=0002, cout=1;
//      sub=1,a=0003,b=0005 -> sum=FFFE, cout=0.

Source files
------------

// File: rtl/serial_adder16.sv
// serial_adder16: bit-serial two-operand adder, LSB first, one bit per clock.
// One full-adder cell with a carry flip-flop walks both operands through shift
// registers. A start/busy/done handshake brackets each WIDTH-cycle operation.
// Optional build macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (B inverted at capture, carry-in forced to 1).
module serial_adder16 #(
  parameter int WIDTH = 16  // legal range 2..32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sra_q, sra_d;
  logic [WIDTH-1:0] srb_q, srb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand B and carry-in as they are loaded on the accepting edge.
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ? 1'b1 : cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  // The single full-adder cell working on the current LSBs.
  logic s_bit, c_next;
  assign s_bit  = sra_q[0] ^ srb_q[0] ^ carry_q;
  assign c_next = (sra_q[0] & srb_q[0]) | (sra_q[0] & carry_q) | (srb_q[0] & carry_q);

  // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    sra_d   = sra_q;
    srb_d   = srb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sra_d   = a;
          srb_d   = b_load;
          carry_d = cin_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        carry_d = c_next;
        sra_d   = sra_q >> 1;
        srb_d   = srb_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the whole result at once; sum/cout never show partial bits.
          state_d = DONE;
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sra_q   <= '0;
      srb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      state_q <= state_d;
      sra_q   <= sra_d;
      srb_q   <= srb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder16.sv
// tb_serial_adder16: self-checking bench for serial_adder16 (WIDTH=16).
// Table-driven vectors, hand-written multi-cycle sequences and random
// operations compared against an arithmetic reference model.
module tb_serial_adder16;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a, b;
  logic          cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic          sub;
`endif
  logic [W-1:0]  sum;
  logic          cout, busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W:0] exp_last;  // last result the bench expects on {cout,sum}

  serial_adder16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    int unsigned total;
    if (s) total = int'(x) + int'(~y) + 1;
    else   total = int'(x) + int'(y) + int'(c);
    return total[W:0];
  endfunction

  // Drive one operation, scramble inputs after acceptance, check timing and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input string name);
    int k;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    @(negedge clk);  // k = 0: one half-cycle after the accepting edge
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    k = 0;
    while (!done && k < 3 * W) begin
      if (k == W / 2) begin
        check({name, " busy mid-run"}, 32'(busy), 32'd1);
        check({name, " sum held mid-run"}, 32'({cout, sum}), 32'(exp_last));
      end
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(W));
    check({name, " sum"}, 32'(sum), 32'(es));
    check({name, " cout"}, 32'(cout), 32'(ec));
    check({name, " busy at done"}, 32'(busy), 32'd0);
    exp_last = {ec, es};
    @(negedge clk);
    check({name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W:0] m;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    int dcount, first_k, second_k;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    exp_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset sum", 32'(sum), 32'h0);
    check("reset cout", 32'(cout), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);

    // Directed vectors with hand-computed results.
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

    // Start pulsed mid-run is ignored: one done pulse, first operands' result.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    dcount = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (k == 4) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (done) dcount++;
    end
    check("midrun start done count", 32'(dcount), 32'd1);
    check("midrun start sum", 32'({cout, sum}), 32'h05555);
    exp_last = 17'h05555;

    // Reset mid-run aborts at once with no done pulse.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort no done", 32'(dcount), 32'd0);
    exp_last = '0;
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "after abort");

    // Start held high: back-to-back operations, one every W+2 cycles.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; cin = 1'b0; start = 1'b1;
    dcount = 0; first_k = -1; second_k = -1;
    for (int k = 0; k <= 2 * W + 3; k++) begin
      @(negedge clk);
      if (k == 2 * W + 3) start = 1'b0;
      if (done) begin
        dcount++;
        if (first_k < 0) first_k = k; else second_k = k;
      end
    end
    check("held start pulses", 32'(dcount), 32'd2);
    check("held start first", 32'(first_k), 32'(W));
    check("held start second", 32'(second_k), 32'(2 * W + 2));
    check("held start sum", 32'({cout, sum}), 32'h00007);
    exp_last = 17'h00007;
    repeat (2) @(negedge clk);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, m[W-1:0], m[W], $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
